// File: rtl/protocol_arbiter_seq_pkg.sv
// Shared types and constants for the two-requester protocol arbiter/sequencer.
package protocol_arbiter_seq_pkg;

    localparam int unsigned ACK_TIMEOUT_DEF = 4;
    localparam int unsigned ABORT_LEN_DEF   = 2;

    localparam logic [1:0] E_IDLE  = 2'b00;
    localparam logic [1:0] E_START = 2'b01;
    localparam logic [1:0] E_OPA   = 2'b10;
    localparam logic [1:0] E_OPB   = 2'b11;
    localparam logic [1:0] Y_ACK   = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ACK,
        ST_CMD,
        ST_CHECK,
        ST_ABORT
    } state_e;

    // Command code seen by the slave is a pure function of state and latched op.
    function automatic logic [1:0] e_code(input state_e st, input logic op_b);
        case (st)
            ST_START, ST_ACK: e_code = E_START;
            ST_CMD:           e_code = op_b ? E_OPB : E_OPA;
            default:          e_code = E_IDLE;
        endcase
    endfunction

    function automatic logic [1:0] onehot2(input logic idx);
        onehot2 = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/protocol_arbiter_seq_if.sv
// Requester and protocol-slave signal bundle for protocol_arbiter_seq.
interface protocol_arbiter_seq_if;
    logic [1:0] req;
    logic [1:0] cmd;
    logic [1:0] E;
    logic [1:0] Y;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [1:0] err;
    logic       busy;
    logic [3:0] err_cnt;

    modport slave  (input  req, cmd, Y, output E, gnt, done, err, busy, err_cnt);
    modport master (output req, cmd, Y, input  E, gnt, done, err, busy, err_cnt);
endinterface

// File: rtl/protocol_arbiter_seq_rr.sv
// Two-requester round-robin arbiter; pointer hands priority to the non-owner on advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       owner,
    output logic       winner,
    output logic       valid
);

    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = ~owner;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        winner = ptr_q;
        if (req == 2'b01)      winner = 1'b0;
        else if (req == 2'b10) winner = 1'b1;
    end

    assign valid = |req;

endmodule

// File: rtl/protocol_arbiter_seq.sv
// Arbitrates two requesters onto a START/ACK/CMD/CHECK protocol slave with timeout and abort.
module protocol_arbiter_seq
    import protocol_arbiter_seq_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int unsigned ABORT_LEN   = ABORT_LEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    protocol_arbiter_seq_if.slave  bus
);

    localparam int unsigned CNT_MAX = (ACK_TIMEOUT > ABORT_LEN) ? ACK_TIMEOUT : ABORT_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e             state_q, state_d;
    logic               owner_q, owner_d;
    logic               op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         e_q, e_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         done_q, done_d;
    logic [1:0]         err_q, err_d;
    logic               busy_q, busy_d;
    logic [3:0]         err_cnt_q, err_cnt_d;
    logic               advance;
    logic               winner;
    logic               valid;

    rr_arb2 u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.req),
        .advance (advance),
        .owner   (owner_q),
        .winner  (winner),
        .valid   (valid)
    );

    // Next-state, counters and next values of every registered output.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        done_d  = 2'b00;
        err_d   = 2'b00;
        advance = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    owner_d = winner;
                    op_d    = bus.cmd[winner];
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_ACK;
            end
            ST_ACK: begin
                if (bus.Y == Y_ACK) begin
                    state_d = ST_CMD;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_ABORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CMD: state_d = ST_CHECK;
            ST_CHECK: begin
                if (bus.Y == e_code(ST_CMD, op_q)) begin
                    done_d  = onehot2(owner_q);
                    advance = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (cnt_q == CNT_W'(ABORT_LEN - 1)) begin
                    err_d   = onehot2(owner_q);
                    advance = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        gnt_d     = (state_d == ST_IDLE) ? 2'b00 : onehot2(owner_d);
        e_d       = e_code(state_d, op_d);
        busy_d    = (state_d != ST_IDLE);
        err_cnt_d = err_cnt_q;
        if ((err_d != 2'b00) && (err_cnt_q != 4'hF)) err_cnt_d = err_cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            op_q      <= 1'b0;
            cnt_q     <= '0;
            e_q       <= E_IDLE;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            busy_q    <= 1'b0;
            err_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            e_q       <= e_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.E       = e_q;
    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
    assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_protocol_arbiter_seq.sv
// Scoreboard bench for protocol_arbiter_seq: stimulus queues expected completions, a monitor checks them.
module tb_protocol_arbiter_seq;
    import protocol_arbiter_seq_pkg::*;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [1:0]  done;
        logic [1:0]  err;
        logic [3:0]  ecnt;
        logic [4:0]  len;
        logic [31:0] tr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   slave_mode = 0;   // 0 compliant, 1 silent in ACK, 2 answers op A in CHECK
    exp_t exp_q[$];

    protocol_arbiter_seq_if bus ();

    protocol_arbiter_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req_v);
        end
    endtask

    task automatic push_exp(input logic [1:0] g, input logic [1:0] d, input logic [1:0] e,
                            input logic [3:0] c, input int l, input logic [31:0] t);
        exp_t x;
        x.gnt = g; x.done = d; x.err = e; x.ecnt = c; x.len = 5'(l); x.tr = t;
        exp_q.push_back(x);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if ((bus.done | bus.err) != 2'b00) seen++;
        end
        chk("pulse_count", 32'(seen), 32'(n));
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = 2'b00;
        bus.cmd = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Protocol slave model, updated away from the active edge.
    initial begin
        logic [1:0] last_op;
        last_op = E_OPA;
        bus.Y   = 2'b00;
        forever begin
            @(negedge clk);
            if (bus.E == E_START)  bus.Y = (slave_mode == 1) ? 2'b00 : Y_ACK;
            else if (bus.E[1]) begin
                last_op = bus.E;
                bus.Y   = 2'b00;
            end else               bus.Y = (slave_mode == 2) ? E_OPA : last_op;
        end
    end

    // Monitor: collects E while granted, checks each done/err pulse against the queue.
    initial begin
        logic [31:0] tr;
        int          tr_len;
        logic        gnt_bad;
        exp_t        x;
        tr = '0; tr_len = 0; gnt_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tr = '0; tr_len = 0; gnt_bad = 1'b0;
            end else begin
                if (bus.gnt != 2'b00) begin
                    tr = {tr[29:0], bus.E};
                    tr_len++;
                    if (exp_q.size() > 0 && bus.gnt != exp_q[0].gnt) gnt_bad = 1'b1;
                end
                if ((bus.done | bus.err) != 2'b00) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", {28'd0, bus.done, bus.err}, 32'd0);
                    end else begin
                        x = exp_q.pop_front();
                        chk("done_err", {28'd0, bus.done, bus.err}, {28'd0, x.done, x.err});
                        chk("err_cnt", 32'(bus.err_cnt), 32'(x.ecnt));
                        chk("e_trace", {tr[26:0], 5'(tr_len)}, {x.tr[26:0], x.len});
                        chk("gnt_owner", 32'(gnt_bad), 32'd0);
                    end
                    tr = '0; tr_len = 0; gnt_bad = 1'b0;
                end
            end
        end
    end

    initial begin
        int cyc;
        bus.req = 2'b00;
        bus.cmd = 2'b00;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_E", 32'(bus.E), 32'd0);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);

        // Single requester, op A; cmd flipped after grant must not matter.
        do_reset();
        slave_mode = 0;
        push_exp(2'b01, 2'b01, 2'b00, 4'd0, 4, 32'h58);
        bus.req = 2'b01; bus.cmd = 2'b00;
        @(negedge clk);
        chk("t1_grant_latency", 32'(bus.gnt), 32'h1);
        bus.cmd = 2'b01;
        wait_pulses(1, 20);
        bus.req = 2'b00; bus.cmd = 2'b00;
        @(negedge clk);

        // Both requesting: alternate 0 (op A), 1 (op B), 0.
        do_reset();
        push_exp(2'b01, 2'b01, 2'b00, 4'd0, 4, 32'h58);
        push_exp(2'b10, 2'b10, 2'b00, 4'd0, 4, 32'h5C);
        push_exp(2'b01, 2'b01, 2'b00, 4'd0, 4, 32'h58);
        bus.req = 2'b11; bus.cmd = 2'b10;
        wait_pulses(3, 40);
        bus.req = 2'b00;
        @(negedge clk);

        // Requester 1 drops req right after grant; transaction still completes.
        push_exp(2'b10, 2'b10, 2'b00, 4'd0, 4, 32'h5C);
        bus.req = 2'b10; bus.cmd = 2'b10;
        @(negedge clk);
        bus.req = 2'b00;
        wait_pulses(1, 20);
        @(negedge clk);

        // Silent slave: 4 ACK cycles, 2 ABORT cycles, err.
        slave_mode = 1;
        push_exp(2'b01, 2'b00, 2'b01, 4'd1, 7, 32'h1550);
        bus.req = 2'b01; bus.cmd = 2'b00;
        wait_pulses(1, 20);
        bus.req = 2'b00;
        @(negedge clk);

        // Op B answered with op A code: CHECK aborts.
        slave_mode = 2;
        push_exp(2'b10, 2'b00, 2'b10, 4'd2, 6, 32'h5C0);
        bus.req = 2'b10; bus.cmd = 2'b10;
        wait_pulses(1, 20);
        bus.req = 2'b00;
        @(negedge clk);

        // Reset during CMD: outputs clear at once, no pulse, next grant to requester 0.
        slave_mode = 0;
        bus.req = 2'b10; bus.cmd = 2'b00;
        @(negedge clk);
        bus.req = 2'b01;
        cyc = 0;
        while (bus.E != E_OPA && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_reached_cmd", 32'(bus.E), 32'(E_OPA));
        rst_n = 1'b0;
        #1;
        chk("t6_async_E", 32'(bus.E), 32'd0);
        chk("t6_async_gnt", 32'(bus.gnt), 32'd0);
        chk("t6_async_busy", 32'(bus.busy), 32'd0);
        bus.req = 2'b11; bus.cmd = 2'b10;
        repeat (2) @(negedge clk);
        push_exp(2'b01, 2'b01, 2'b00, 4'd0, 4, 32'h58);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_first_grant", 32'(bus.gnt), 32'h1);
        wait_pulses(1, 20);
        bus.req = 2'b00;
        @(negedge clk);

        // 17 failures: err_cnt saturates at 15.
        do_reset();
        slave_mode = 2;
        for (int i = 1; i <= 17; i++)
            push_exp(2'b01, 2'b00, 2'b01, (i > 15) ? 4'd15 : 4'(i), 6, 32'h5C0);
        bus.req = 2'b01; bus.cmd = 2'b01;
        wait_pulses(17, 17 * 12);
        bus.req = 2'b00;
        repeat (3) @(negedge clk);
        chk("t7_err_cnt_sat", 32'(bus.err_cnt), 32'd15);

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
